// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the unicycle MIPS fetch stage: opcodes, fetch FSM states, reset PC.
package pkg_mips;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [WORD_W-1:0] RESET_PC_PADRAO = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } estado_t;

endpackage

// File: rtl/busca_instrucao_calc_prox_pc.sv
// Next-PC computation: sequential, beq-taken or j target (jump has priority).
module calc_prox_pc
  import pkg_mips::*;
(
  input  logic [WORD_W-1:0] PC,
  input  logic [WORD_W-1:0] Instr,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              Jump,
  output logic [WORD_W-1:0] PCmais4,
  output logic [WORD_W-1:0] PC_next
);

  logic [WORD_W-1:0] desloc;
  logic              unused_op;

  // Sign-extend the 16-bit offset to 32 bits, then scale to bytes.
  assign desloc    = {{14{Instr[15]}}, Instr[15:0], 2'b00};
  assign unused_op = ^Instr[31:26];
  assign PCmais4   = PC + 32'd4;

  always_comb begin
    PC_next = PCmais4;
    if (Jump) begin
      PC_next = {PCmais4[31:28], Instr[25:0], 2'b00};
    end else if (Branch && Zero) begin
      PC_next = PCmais4 + desloc;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns PC, fetches one word at a time from variable-latency memory
// and holds it in the instruction register until the datapath retires it.
module busca_instrucao
  import pkg_mips::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_PADRAO,
  parameter int unsigned CONT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       Instr,
  output logic [5:0]        Op,
  output logic              InstrValida,
  output logic [31:0]       PC,
  output logic [31:0]       PCmais4,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              Jump,
  input  logic              Avanca,
  output logic [CONT_W-1:0] ContInstr
);

  if (RESET_PC[1:0] != 2'b00) begin : g_chk_reset_pc
    $error("busca_instrucao: RESET_PC must be word aligned");
  end

  estado_t     estado, estado_prox;
  logic        req_prox;
  logic        carrega_instr;
  logic        retira;
  logic [31:0] pc_next;

  calc_prox_pc u_calc_prox_pc (
    .PC      (PC),
    .Instr   (Instr),
    .Branch  (Branch),
    .Zero    (Zero),
    .Jump    (Jump),
    .PCmais4 (PCmais4),
    .PC_next (pc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= FETCH;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      FETCH: if (imem_req && imem_ready) estado_prox = EXEC;
      EXEC:  if (Avanca) estado_prox = FETCH;
    endcase
  end

  // Request is held low during reset and rises one edge later, so a response in flight is dropped.
  always_comb begin
    carrega_instr = 1'b0;
    retira        = 1'b0;
    req_prox      = imem_req;
    case (estado)
      FETCH: begin
        carrega_instr = imem_req && imem_ready;
        req_prox      = !carrega_instr;
      end
      EXEC: begin
        retira   = Avanca;
        req_prox = Avanca;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req  <= 1'b0;
      PC        <= RESET_PC;
      Instr     <= '0;
      ContInstr <= '0;
    end else begin
      imem_req <= req_prox;
      if (carrega_instr) begin
        Instr <= imem_rdata;
      end
      if (retira) begin
        PC        <= pc_next;
        ContInstr <= ContInstr + CONT_W'(1);
      end
    end
  end

  assign imem_addr   = PC;
  assign Op          = Instr[31:26];
  assign InstrValida = (estado == EXEC);

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: transaction-level reference model plus directed literals.
module tb_busca_instrucao;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] Instr;
  logic [5:0]  Op;
  logic        InstrValida;
  logic [31:0] PC;
  logic [31:0] PCmais4;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump = 1'b0;
  logic        Avanca = 1'b0;
  logic [31:0] ContInstr;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  busca_instrucao #(
    .RESET_PC (32'h0000_0000),
    .CONT_W   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .Instr       (Instr),
    .Op          (Op),
    .InstrValida (InstrValida),
    .PC          (PC),
    .PCmais4     (PCmais4),
    .Branch      (Branch),
    .Zero        (Zero),
    .Jump        (Jump),
    .Avanca      (Avanca),
    .ContInstr   (ContInstr)
  );

  task automatic check32(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic check1(input string nome, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nome, act, exp, $time);
    end
  endtask

  // Next PC from the ISA rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic b, input logic z, input logic j);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 32'd4;
    if (b && z) begin
      off = int'($signed(ins[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // Reference model: one instruction at a time, fetched then retired.
  logic [31:0] m_pc, m_instr, m_cnt;
  logic        m_valid, m_req;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
      m_cnt   <= 32'h0;
      m_valid <= 1'b0;
      m_req   <= 1'b0;
    end else if (!m_valid) begin
      if (m_req && imem_ready) begin
        m_instr <= imem_rdata;
        m_valid <= 1'b1;
        m_req   <= 1'b0;
      end else begin
        m_req <= 1'b1;
      end
    end else if (Avanca) begin
      m_pc    <= model_next(m_pc, m_instr, Branch, Zero, Jump);
      m_cnt   <= m_cnt + 32'd1;
      m_valid <= 1'b0;
      m_req   <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("imem_req", imem_req, m_req);
      if (m_req) check32("imem_addr", imem_addr, m_pc);
      check1("InstrValida", InstrValida, m_valid);
      check32("Instr", Instr, m_instr);
      check32("Op", 32'(Op), 32'(m_instr[31:26]));
      check32("PC", PC, m_pc);
      check32("PCmais4", PCmais4, m_pc + 32'd4);
      check32("ContInstr", ContInstr, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory side: wait for a request, answer after lat extra cycles.
  task automatic fetch(input logic [31:0] word, input int lat, input logic noise);
    int n;
    n = 0;
    imem_ready = 1'b0;
    while (imem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check1("req_seen", imem_req, 1'b1);
    repeat (lat) begin
      if (noise) Avanca = 1'($urandom);
      imem_rdata = $urandom;
      step();
    end
    Avanca     = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Datapath side: stall wait_c cycles, then retire with the given control bits.
  task automatic exec(input int wait_c, input logic b, input logic z, input logic j, input logic noise);
    repeat (wait_c) begin
      Branch = 1'($urandom);
      Zero   = 1'($urandom);
      Jump   = 1'($urandom);
      if (noise) imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      step();
    end
    imem_ready = 1'b0;
    Branch = b;
    Zero   = z;
    Jump   = j;
    Avanca = 1'b1;
    step();
    Avanca = 1'b0;
    Branch = 1'($urandom);
    Zero   = 1'($urandom);
    Jump   = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk_en = 1'b1;
    check32("rst_PC", PC, 32'h0);
    check32("rst_Instr", Instr, 32'h0);
    check1("rst_valid", InstrValida, 1'b0);
    check1("rst_req", imem_req, 1'b0);
    check32("rst_cont", ContInstr, 32'h0);

    // Zero-wait memory, retire in the cycle InstrValida rises.
    reset = 1'b0;
    step();
    check1("t1_req", imem_req, 1'b1);
    check32("t1_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_ready = 1'b0;
    check32("t1_op", 32'(Op), 32'h08);
    check1("t1_valid", InstrValida, 1'b1);
    exec(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check32("t1_pc", PC, 32'h4);
    check32("t1_cont", ContInstr, 32'h1);
    check1("t1_req2", imem_req, 1'b1);
    check32("t1_addr2", imem_addr, 32'h4);

    // Three-cycle delayed response: request held four cycles.
    for (int k = 0; k < 4; k++) begin
      check1("t2_req", imem_req, 1'b1);
      check32("t2_addr", imem_addr, 32'h4);
      check1("t2_valid", InstrValida, 1'b0);
      check32("t2_instr_hold", Instr, 32'h2008_0005);
      if (k == 3) begin
        imem_ready = 1'b1;
        imem_rdata = 32'h0800_0010;
      end
      step();
    end
    imem_ready = 1'b0;
    check1("t2_valid_up", InstrValida, 1'b1);
    check32("t2_instr", Instr, 32'h0800_0010);
    exec(2, 1'b0, 1'b0, 1'b1, 1'b0);
    check32("t2_pc_j", PC, 32'h40);

    // beq taken / not taken.
    fetch(32'h1000_FFFE, 1, 1'b1);
    exec(1, 1'b1, 1'b1, 1'b0, 1'b1);
    check32("beq_taken", PC, 32'h3C);
    fetch(32'h0800_0010, 0, 1'b0);
    exec(0, 1'b0, 1'b0, 1'b1, 1'b0);
    check32("j_back", PC, 32'h40);
    fetch(32'h1000_FFFE, 2, 1'b1);
    exec(0, 1'b1, 1'b0, 1'b0, 1'b1);
    check32("beq_not_taken", PC, 32'h44);

    // Backward branch to the top of the address space, then wrap.
    fetch(32'h1000_FFED, 0, 1'b0);
    exec(0, 1'b1, 1'b1, 1'b0, 1'b0);
    check32("to_top", PC, 32'hFFFF_FFFC);
    check32("top_p4", PCmais4, 32'h0);
    fetch(32'h0000_0020, 0, 1'b0);
    exec(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check32("wrap_pc", PC, 32'h0);
    check32("wrap_p4", PCmais4, 32'h4);

    // Climb into the 0x1000_0000 region, then check jump priority over a taken branch.
    fetch(32'h0BFF_FFFC, 0, 1'b0);
    exec(0, 1'b0, 1'b0, 1'b1, 1'b0);
    check32("j_far", PC, 32'h0FFF_FFF0);
    repeat (4) begin
      fetch(32'h0000_0020, 0, 1'b0);
      exec(0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check32("cross_nibble", PC, 32'h1000_0000);
    fetch(32'h0800_0004, 0, 1'b0);
    exec(0, 1'b0, 1'b0, 1'b1, 1'b0);
    check32("j_region", PC, 32'h1000_0010);
    fetch(32'h0800_0100, 0, 1'b0);
    exec(0, 1'b1, 1'b1, 1'b1, 1'b0);
    check32("j_priority", PC, 32'h1000_0400);

    // Randomized traffic with noise on ignored inputs.
    for (int i = 0; i < 300; i++) begin
      fetch($urandom, int'($urandom_range(0, 3)), 1'b1);
      exec(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end

    // Reset while a request is outstanding; response during reset is dropped.
    step();
    check1("mid_req", imem_req, 1'b1);
    reset = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    step();
    step();
    imem_ready = 1'b0;
    check32("mid_PC", PC, 32'h0);
    check32("mid_Instr", Instr, 32'h0);
    check1("mid_valid", InstrValida, 1'b0);
    check32("mid_cont", ContInstr, 32'h0);
    check1("mid_req_low", imem_req, 1'b0);
    reset = 1'b0;
    step();
    check1("fresh_req", imem_req, 1'b1);
    check32("fresh_addr", imem_addr, 32'h0);
    check1("fresh_valid", InstrValida, 1'b0);
    fetch(32'h2008_0005, 0, 1'b0);
    exec(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check32("post_pc", PC, 32'h4);
    check32("post_cont", ContInstr, 32'h1);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
- Instruction-fetch stage of the unicycle MIPS core; sits directly upstream of the main control decoder and feeds it the opcode field.
- Owns the PC register and runs a request/ready handshake with instruction memory, which has variable latency.
- Holds the fetched word in an instruction register until the datapath signals completion.
- On completion, computes the next PC (sequential, beq-taken or j target) and starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CONT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the requested word (= PC).
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- imem_ready  input  1  memory completion strobe, sampled only while imem_req=1.
- Instr  output  32  instruction register contents.
- Op  output  6  Instr[31:26]; goes to the control decoder.
- InstrValida  output  1  Instr/Op hold a valid instruction being executed.
- PC  output  32  address of the current instruction.
- PCmais4  output  32  PC+4, for the datapath.
- Branch  input  1  from the control decoder.
- Zero  input  1  ALU zero flag.
- Jump  input  1  from the control decoder.
- Avanca  input  1  datapath has completed the current instruction (writes committed).
- ContInstr  output  CONT_W  count of retired instructions.

Behaviour:
- Reset (async, any state including mid-fetch):
  - PC=RESET_PC; Instr=0; InstrValida=0; imem_req=0; ContInstr=0; state=FETCH.
  - An outstanding memory response is discarded.
  - The first request is issued in the first cycle after reset deasserts.
- States: FETCH, EXEC.
- FETCH:
  - imem_req=1 and imem_addr=PC, held stable until imem_ready.
  - On imem_ready=1: Instr<=imem_rdata; InstrValida<=1 at the next edge; go to EXEC.
  - The minimum latency is one cycle: imem_ready in the first request cycle gives InstrValida=1 in the following cycle.
- EXEC:
  - imem_req=0; InstrValida=1; Op=Instr[31:26] (combinational from the instruction register).
  - Avanca=0: hold indefinitely with no change.
  - Avanca=1: PC<=PC_next; ContInstr<=ContInstr+1 (wraps modulo 2^CONT_W); InstrValida<=0; go to FETCH.
  - Avanca=1 in the same cycle InstrValida first rises is legal.
- Avanca outside EXEC: ignored.
- imem_ready when imem_req=0: ignored.
- PC_next is combinational, with this priority:
  - Jump=1: {PCmais4[31:28], Instr[25:0], 2'b00}. Jump wins when Jump and Branch are both 1.
  - Branch=1 and Zero=1: PCmais4 + (sign_extend(Instr[15:0]) << 2).
  - Otherwise: PCmais4.
- Arithmetic:
  - All adders are 32-bit, modulo 2^32. PC=FFFF_FFFC yields PCmais4=0000_0000, with no error.
  - Branch offset is sign-extended to 32 bits before the shift.
- Alignment: PC[1:0] is always 0 by construction. RESET_PC[1:0]≠0 is a configuration error: flag it with an elaboration-time check.
- Branch, Zero and Jump are sampled only in the Avanca cycle and may be X elsewhere.
- No speculative prefetch: at most one outstanding request.

Decomposition:
- Shared package (pkg_mips) holds:
  - opcode constants: OP_RTYPE 000000, OP_J 000010, OP_BEQ 000100, OP_LW 100011, OP_SW 101011, OP_ADDI 001000.
  - the state enum FETCH/EXEC.
  - the default RESET_PC.
- One natural sub-module: calc_prox_pc, purely combinational.
  - Inputs: PC, Instr, Branch, Zero, Jump.
  - Outputs: PCmais4, PC_next.
  - Reusable by a later pipelined version.

Test Plan:
- Reset then zero-wait memory: mem returns 0x20080005 (addi) with ready on the first request cycle, Avanca one cycle later, then advance on PC=0 → cycle 1 imem_addr=0; cycle 2 Op=001000, InstrValida=1; next fetch at PC=4; ContInstr=1.
- Variable latency: ready delayed 3 cycles → imem_req and imem_addr=PC held stable for 4 cycles, InstrValida=0 throughout, Instr unchanged until ready.
- Taken and not-taken beq:
  - PC=0x40, Instr=0x1000FFFE, Branch=1, Zero=1, Avanca → PC=0x3C.
  - Same with Zero=0 → PC=0x44.
- Jump priority: PC=0x1000_0010, Instr=0x08000100, Jump=1 and Branch=Zero=1 → PC=0x1000_0400.
- Wrap: PC=0xFFFF_FFFC, sequential advance → PC=0x0000_0000, PCmais4=0x0000_0004.
- Reset mid-fetch: assert reset while imem_req=1, then pulse imem_ready during reset → PC=RESET_PC, Instr=0, InstrValida=0, ContInstr=0; a fresh request is issued after deassertion.
